// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/flag inputs and control strobes between controller and datapath.
interface multicycle_ctrl_if;
    logic [5:0] op;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic [3:0] state;
    modport master (
        input  op, zero,
        output pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, aluop, state
    );
    modport slave (
        output op, zero,
        input  pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord,
               memtoreg, regdst, pcsrc, aluop, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS-style datapath.
module multicycle_ctrl (
    input logic               clk,
    input logic               reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2, MEMRD  = 4'd3,
        MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
        BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
    } state_t;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    state_t r_state;
    logic   w_pcwrite;
    logic   w_branch;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:   r_state <= DECODE;
                DECODE:  r_state <= (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                                    (bus.op == OP_R)    ? RTYPEEX :
                                    (bus.op == OP_BEQ)  ? BEQEX   :
                                    (bus.op == OP_ADDI) ? ADDIEX  :
                                    (bus.op == OP_J)    ? JEX     : FETCH;
                MEMADR:  r_state <= (bus.op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:   r_state <= MEMWB;
                RTYPEEX: r_state <= RTYPEWB;
                ADDIEX:  r_state <= ADDIWB;
                default: r_state <= FETCH;
            endcase
        end
    end
    // Outputs are forced low while reset is held, even though the state already reads FETCH.
    always_comb begin
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        bus.memwrite = 1'b0;
        bus.irwrite  = 1'b0;
        bus.regwrite = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = 2'b00;
        bus.iord     = 1'b0;
        bus.memtoreg = 1'b0;
        bus.regdst   = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.aluop    = 2'b00;
        if (!reset) begin
            case (r_state)
                FETCH:   begin bus.irwrite = 1'b1; w_pcwrite = 1'b1; bus.alusrcb = 2'b01; end
                DECODE:  bus.alusrcb = 2'b11;
                MEMADR:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
                MEMRD:   bus.iord = 1'b1;
                MEMWB:   begin bus.regwrite = 1'b1; bus.memtoreg = 1'b1; end
                MEMWR:   begin bus.iord = 1'b1; bus.memwrite = 1'b1; end
                RTYPEEX: begin bus.alusrca = 1'b1; bus.aluop = 2'b10; end
                RTYPEWB: begin bus.regwrite = 1'b1; bus.regdst = 1'b1; end
                BEQEX:   begin bus.alusrca = 1'b1; bus.aluop = 2'b01; bus.pcsrc = 2'b01; w_branch = 1'b1; end
                ADDIEX:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
                ADDIWB:  bus.regwrite = 1'b1;
                JEX:     begin w_pcwrite = 1'b1; bus.pcsrc = 2'b10; end
                default: ;
            endcase
        end
        bus.pcen = w_pcwrite | (w_branch & bus.zero);
    end
    assign bus.state = r_state;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters SHALL be none; state encoding and opcode values are fixed by this document.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register.
REQ-005 zero  input  1  ALU zero flag from the current cycle.
REQ-006 pcen  output  1  PC register enable.
REQ-007 memwrite  output  1  memory write strobe.
REQ-008 irwrite  output  1  instruction register load enable.
REQ-009 regwrite  output  1  register file write enable.
REQ-010 alusrca  output  1  ALU A select: 0 = PC, 1 = rs register.
REQ-011 alusrcb  output  2  ALU B select: 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
REQ-012 iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-013 memtoreg  output  1  write-back data select: 0 = ALUOut, 1 = memory data.
REQ-014 regdst  output  1  destination register select: 0 = rt, 1 = rd.
REQ-015 pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-016 aluop  output  2  to the ALU decoder: 00 = add, 01 = sub, 10 = R-type decoded by funct.
REQ-017 state  output  4  current state, for debug and the bench.

Function
REQ-018 The block SHALL be a Moore FSM.
- Every output except pcen SHALL be a function of state only.
- pcen SHALL be the combinational term pcwrite | (branch & zero), where pcwrite and branch are internal per-state signals.
REQ-019 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-020 Any signal not listed for a state in REQ-021..REQ-032 SHALL be 0 in that state.
REQ-021 FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00, iord=0, pcsrc=00; next state DECODE.
REQ-022 DECODE: alusrcb=11, aluop=00. Next state by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> RTYPEEX
- 000100 -> BEQEX
- 001000 -> ADDIEX
- 000010 -> JEX
- any other op -> FETCH, with no write strobe asserted.
REQ-023 MEMADR: alusrca=1, alusrcb=10, aluop=00; next state MEMRD if op=100011, else MEMWR.
REQ-024 MEMRD: iord=1; next state MEMWB.
REQ-025 MEMWB: regwrite=1, memtoreg=1, regdst=0; next state FETCH.
REQ-026 MEMWR: iord=1, memwrite=1; next state FETCH.
REQ-027 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next state RTYPEWB.
REQ-028 RTYPEWB: regwrite=1, regdst=1, memtoreg=0; next state FETCH.
REQ-029 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; next state FETCH regardless of zero.
REQ-030 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next state ADDIWB.
REQ-031 ADDIWB: regwrite=1, regdst=0, memtoreg=0; next state FETCH.
REQ-032 JEX: pcwrite=1, pcsrc=10; next state FETCH.
REQ-033 Undefined state codes 12-15 SHALL output all zeros and go to FETCH on the next edge.
REQ-034 Instruction latencies, counted as cycles from FETCH up to and including the last state, SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
REQ-035 op SHALL be sampled only in DECODE and MEMADR. Changes to op in any other state SHALL have no effect.
REQ-036 zero SHALL affect only pcen, and only in BEQEX.
REQ-037 At most one of memwrite, regwrite and irwrite SHALL be high in any cycle.

Reset
REQ-038 Asserting reset SHALL force state=FETCH immediately, without waiting for a clock edge; this applies mid-instruction as well.
REQ-039 While reset is high, every output SHALL be 0, including pcen, irwrite and pcwrite.
REQ-040 FETCH outputs SHALL first appear in the cycle after reset deasserts, and the first state advance SHALL occur on the next rising edge.

Verification
REQ-041 Scenario lw: reset, then op=100011 -> states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4; iord=1 in state 3.
REQ-042 Scenario beq: op=000100 with zero=1 in BEQEX -> pcen=1 with pcsrc=01. Repeating with zero=0 -> pcen=0. Both cases return to FETCH.
REQ-043 Scenario R-type, then addi: op=000000 -> aluop=10 in state 6, regdst=1 in state 7. Then op=001000 -> aluop=00 and alusrcb=10 in state 9, regdst=0 in state 10.
REQ-044 Scenario j and unknown op: op=000010 -> pcen=1, pcsrc=10 in state 11. op=111111 -> DECODE returns to FETCH with memwrite, regwrite and irwrite all 0.
REQ-045 Scenario reset mid-operation: assert reset asynchronously in MEMWR (state 5) -> memwrite drops and state=0 before the next clock edge. Release reset -> normal FETCH follows.
REQ-046 Scenario random op stream of 1000+ instructions: REQ-037 holds in every cycle, and the per-op cycle counts match REQ-034.
